proc_io_bridge: RTL and testbench

- Multi-channel streaming I/O front end for the proc_fl soft float processor; generalises the fixed four-port, unbuffered int2float / float2int / addr_dec wrapper.
- Each of NCH input channels has a valid/ready FIFO of signed integers, popped and converted to float when the processor issues an input request for that address.
- Each of NCH output channels has a one-entry holding register, loaded from converted processor output and drained by a valid/ready consumer.

---
 rtl/proc_io_pkg.sv | 16 +
 rtl/float2int.sv | 33 +++
 rtl/int2float.sv | 26 ++
 rtl/proc_io_fifo.sv | 46 ++++
 rtl/proc_io_bridge.sv | 92 +++++++++
 tb/tb_proc_io_bridge.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/proc_io_pkg.sv
// Shared helpers for proc_io_bridge. The float word is {sign, biased exponent, normalised mantissa with explicit leading one}.
package proc_io_pkg;
  localparam logic [63:0] F_ZERO = '0;

  function automatic int nbw(input int nbmant, input int nbexpo);
    return nbmant + nbexpo + 1;
  endfunction

  function automatic int expo_bias(input int nbexpo);
    return (1 << (nbexpo - 1)) - 1;
  endfunction

  function automatic int sat_lim(input int nbmant);
    return (1 << (nbmant - 1)) - 1;
  endfunction
endpackage

// File: rtl/float2int.sv
// Float to signed integer, truncating toward zero and saturating to +/-(2^(NBMANT-1)-1).
module float2int import proc_io_pkg::*; #(
  parameter int NBMANT = 19,
  parameter int NBEXPO = 8,
  parameter int NBW    = nbw(NBMANT, NBEXPO)
) (
  input  logic [NBW-1:0]    f,
  output logic [NBMANT-1:0] i
);
  localparam int EOFF = expo_bias(NBEXPO) + NBMANT - 1;
  localparam logic [2*NBMANT-1:0] LIM = (2*NBMANT)'(sat_lim(NBMANT));
  logic                sgn;
  logic [NBEXPO-1:0]   e;
  logic [NBMANT-1:0]   m;
  logic [2*NBMANT-1:0] mag;
  int                  sh;

  assign {sgn, e, m} = f;

  always_comb begin
    sh  = int'(e) - EOFF;
    mag = '0;
    if (e != '0 && m != '0) begin
      if (sh >= NBMANT) mag = LIM;
      else if (sh >= 0) begin
        mag = {{NBMANT{1'b0}}, m} << sh;
        if (mag > LIM) mag = LIM;
      end
      else if (-sh < NBMANT) mag = {{NBMANT{1'b0}}, m >> (-sh)};
    end
    i = sgn ? NBMANT'(-mag) : NBMANT'(mag);
  end
endmodule

// File: rtl/int2float.sv
// Signed integer to float: value = mant * 2^(expo - bias - (NBMANT-1)); zero maps to the all-zero word.
module int2float import proc_io_pkg::*; #(
  parameter int NBMANT = 19,
  parameter int NBEXPO = 8,
  parameter int NBW    = nbw(NBMANT, NBEXPO)
) (
  input  logic [NBMANT-1:0] i,
  output logic [NBW-1:0]    f
);
  localparam int MW = $clog2(NBMANT);
  logic [NBMANT-1:0] mag;
  logic [MW-1:0]     msb;

  always_comb begin
    mag = i[NBMANT-1] ? -i : i;
    msb = '0;
    for (int b = 0; b < NBMANT; b++)
      if (mag[b]) msb = MW'(b);
    f = '0;
    if (mag != '0) begin
      f[NBW-1]           = i[NBMANT-1];
      f[NBW-2 -: NBEXPO] = NBEXPO'(expo_bias(NBEXPO) + int'(msb));
      f[NBMANT-1:0]      = mag << (NBMANT - 1 - int'(msb));
    end
  end
endmodule

// File: rtl/proc_io_fifo.sv
// One input channel: DEPTH-entry circular FIFO with registered occupancy count.
module proc_io_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wdata,
  input  logic         push,
  output logic         ready,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wptr, rptr;
  logic [CW-1:0]           count;
  logic                    do_push, do_pop;

  assign ready   = count != CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/proc_io_bridge.sv
// Multi-channel I/O front end for proc_fl: per-channel input FIFOs read as floats, per-channel output holding registers.
// Optional sticky error flags (err_udf, err_ovf) are built when PROC_IO_ERR_EN is defined.
module proc_io_bridge import proc_io_pkg::*; #(
  parameter int NCH    = 4,
  parameter int NBMANT = 19,
  parameter int NBEXPO = 8,
  parameter int DEPTH  = 4,
  parameter int NBW    = nbw(NBMANT, NBEXPO),
  parameter int NBA    = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*NBMANT-1:0] in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [NCH*NBMANT-1:0] out_data,
  output logic [NCH-1:0]        out_valid,
  input  logic [NCH-1:0]        out_ready,
  input  logic                  proc_req_in,
  input  logic [NBA-1:0]        proc_addr_in,
  output logic [NBW-1:0]        proc_din,
  input  logic                  proc_out_en,
  input  logic [NBA-1:0]        proc_addr_out,
  input  logic [NBW-1:0]        proc_dout
`ifdef PROC_IO_ERR_EN
  ,
  output logic [NCH-1:0]        err_udf,
  output logic [NCH-1:0]        err_ovf
`endif
);
  logic [NCH-1:0][NBMANT-1:0] head, odata;
  logic [NCH-1:0]             empty, pop, ld;
  logic [NBMANT-1:0]          sel_int, out_int;
  logic [NBW-1:0]             sel_flt;
  logic                       in_ok, out_ok, din_ok;

  assign in_ok  = {1'b0, proc_addr_in}  < (NBA+1)'(NCH);
  assign out_ok = {1'b0, proc_addr_out} < (NBA+1)'(NCH);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign pop[k] = proc_req_in && in_ok && proc_addr_in == NBA'(k);
    assign ld[k]  = proc_out_en && out_ok && proc_addr_out == NBA'(k);
    assign out_data[k*NBMANT +: NBMANT] = odata[k];

    proc_io_fifo #(.W(NBMANT), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wdata (in_data[k*NBMANT +: NBMANT]),
      .push  (in_valid[k]),
      .ready (in_ready[k]),
      .pop   (pop[k]),
      .head  (head[k]),
      .empty (empty[k])
    );
  end

  // Single converter shared by all channels, after the head mux.
  assign din_ok   = in_ok && !empty[proc_addr_in];
  assign sel_int  = din_ok ? head[proc_addr_in] : '0;
  assign proc_din = din_ok ? sel_flt : F_ZERO[NBW-1:0];

  int2float #(.NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_i2f (.i(sel_int), .f(sel_flt));
  float2int #(.NBMANT(NBMANT), .NBEXPO(NBEXPO)) u_f2i (.f(proc_dout), .i(out_int));

  always_ff @(posedge clk) begin
    if (rst) begin
      odata     <= '0;
      out_valid <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ld[k]) begin
          odata[k]     <= out_int;
          out_valid[k] <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef PROC_IO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_udf <= '0;
      err_ovf <= '0;
    end else begin
      err_udf <= err_udf | (pop & empty);
      err_ovf <= err_ovf | (ld & out_valid & ~out_ready);
    end
  end
`endif
endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed bench for proc_io_bridge; checks err flags too when PROC_IO_ERR_EN is defined.
module tb_proc_io_bridge;
  localparam int NCH = 4, NBM = 19, NBW = 28, NBA = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH*NBM-1:0]  in_data, out_data;
  logic [NCH-1:0]      in_valid, in_ready, out_valid, out_ready;
  logic                proc_req_in, proc_out_en;
  logic [NBA-1:0]      proc_addr_in, proc_addr_out;
  logic [NBW-1:0]      proc_din, proc_dout;
`ifdef PROC_IO_ERR_EN
  logic [NCH-1:0]      err_udf, err_ovf;
`endif

  proc_io_bridge dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .proc_req_in(proc_req_in), .proc_addr_in(proc_addr_in), .proc_din(proc_din),
    .proc_out_en(proc_out_en), .proc_addr_out(proc_addr_out), .proc_dout(proc_dout)
`ifdef PROC_IO_ERR_EN
    , .err_udf(err_udf), .err_ovf(err_ovf)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [NBM-1:0] ti(input int v);
    return v[NBM-1:0];
  endfunction

  function automatic logic [NBM-1:0] od(input int k);
    return out_data[k*NBM +: NBM];
  endfunction

  // Reference encoder: scale |r| into [2^18, 2^19), truncate, exponent = 127 + 18 - scale.
  function automatic logic [NBW-1:0] r2f(input real r);
    real a;
    int  k, e;
    logic [NBM-1:0] m;
    if (r == 0.0) return '0;
    a = (r < 0.0) ? -r : r;
    k = 0;
    while (a >= 524288.0) begin a = a / 2.0; k--; end
    while (a < 262144.0)  begin a = a * 2.0; k++; end
    m = NBM'($rtoi(a));
    e = 127 + NBM - 1 - k;
    return {(r < 0.0), e[7:0], m};
  endfunction

  task automatic push(input int ch, input int v);
    in_data[ch*NBM +: NBM] = ti(v);
    in_valid[ch] = 1'b1;
    tick;
    in_valid[ch] = 1'b0;
  endtask

  task automatic pop(input int ch);
    proc_addr_in = NBA'(ch);
    proc_req_in  = 1'b1;
    tick;
    proc_req_in  = 1'b0;
  endtask

  task automatic wr(input int ch, input real r);
    proc_addr_out = NBA'(ch);
    proc_dout     = r2f(r);
    proc_out_en   = 1'b1;
    tick;
    proc_out_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = '0;
    proc_req_in = 1'b0; proc_addr_in = '0; proc_out_en = 1'b0;
    proc_addr_out = '0; proc_dout = '0;
    tick; tick;
    rst = 1'b0; #1;
    chk("rst_in_ready", in_ready, 4'hF);
    chk("rst_out_valid", out_valid, 4'h0);
    chk("rst_out_data", out_data, '0);
    chk("rst_din", proc_din, '0);
`ifdef PROC_IO_ERR_EN
    chk("rst_err", {err_udf, err_ovf}, '0);
`endif

    // channel 2: in-order reads, hand-encoded floats
    push(2, 5); push(2, -3);
    chk("ch2_ready", in_ready[2], 1'b1);
    proc_addr_in = 2; #1;
    chk("ch2_rd5", proc_din, 28'h40D0000);
    pop(2);
    chk("ch2_rdm3", proc_din, 28'hC060000);
    pop(2);
    chk("ch2_empty", proc_din, '0);

    // channel 0: fill to DEPTH, overflow attempt, then drain
    push(0, 10); push(0, 11); push(0, 12);
    chk("ch0_ready3", in_ready[0], 1'b1);
    push(0, 13);
    chk("ch0_full", in_ready[0], 1'b0);
    push(0, 99);
    chk("ch0_full2", in_ready[0], 1'b0);
    proc_addr_in = 0; #1;
    chk("ch0_rd10", proc_din, 28'h4150000);
    pop(0);
    chk("ch0_ready_pop", in_ready[0], 1'b1);
    chk("ch0_rd11", proc_din, r2f(11.0));
    pop(0);
    chk("ch0_rd12", proc_din, r2f(12.0));
    pop(0);
    chk("ch0_rd13", proc_din, r2f(13.0));
    pop(0);
    chk("ch0_no99", proc_din, '0);

    // underflow on channel 1 leaves pointers intact
    proc_addr_in = 1; #1;
    chk("udf_din", proc_din, '0);
    pop(1);
`ifdef PROC_IO_ERR_EN
    chk("udf_flag", err_udf, 4'b0010);
`endif
    push(1, -7);
    chk("udf_after_push", proc_din, r2f(-7.0));
    pop(1);

    // output path
    wr(3, 1234.7);
    chk("o3_data", od(3), ti(1234));
    chk("o3_valid", out_valid[3], 1'b1);
`ifdef PROC_IO_ERR_EN
    chk("o3_noovf", err_ovf, 4'b0000);
`endif
    wr(3, -9.9);
    chk("o3_overwrite", od(3), ti(-9));
    chk("o3_valid2", out_valid[3], 1'b1);
`ifdef PROC_IO_ERR_EN
    chk("o3_ovf", err_ovf, 4'b1000);
`endif
    out_ready[3] = 1'b1; tick; out_ready[3] = 1'b0;
    chk("o3_drain", out_valid[3], 1'b0);
    wr(1, 1.0e9);
    chk("o1_satp", od(1), ti(262143));
    out_ready[1] = 1'b1;
    wr(1, -1.0e9);
    out_ready[1] = 1'b0;
    chk("o1_satn", od(1), ti(-262143));
    chk("o1_valid", out_valid[1], 1'b1);
`ifdef PROC_IO_ERR_EN
    chk("o1_noovf", err_ovf[1], 1'b0);
`endif

    // simultaneous push and pop on channel 3 holding 2 entries
    push(3, 21); push(3, 22);
    proc_addr_in = 3; #1;
    chk("sim_head21", proc_din, r2f(21.0));
    in_data[3*NBM +: NBM] = ti(23);
    in_valid[3] = 1'b1; proc_req_in = 1'b1;
    tick;
    in_valid[3] = 1'b0; proc_req_in = 1'b0;
    chk("sim_head22", proc_din, r2f(22.0));
    push(3, 24);
    chk("sim_cnt3", in_ready[3], 1'b1);
    push(3, 25);
    chk("sim_cnt4", in_ready[3], 1'b0);
    pop(3);
    chk("sim_rd23", proc_din, r2f(23.0));
    pop(3);
    chk("sim_rd24", proc_din, r2f(24.0));
    pop(3);
    chk("sim_rd25", proc_din, r2f(25.0));
    pop(3);
    chk("sim_empty", proc_din, '0);

    // reset mid-burst dominates push, pop and load
    push(0, 1); push(2, 2);
    wr(0, 5.0);
    rst = 1'b1; in_valid = 4'hF; proc_req_in = 1'b1; proc_addr_in = 2; proc_out_en = 1'b1;
    tick;
    rst = 1'b0; in_valid = '0; proc_req_in = 1'b0; proc_out_en = 1'b0; #1;
    chk("mrst_in_ready", in_ready, 4'hF);
    chk("mrst_out_valid", out_valid, 4'h0);
    chk("mrst_out_data", out_data, '0);
    chk("mrst_din2", proc_din, '0);
    proc_addr_in = 0; #1;
    chk("mrst_din0", proc_din, '0);
`ifdef PROC_IO_ERR_EN
    chk("mrst_err", {err_udf, err_ovf}, '0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
